uart_number_rx: RTL and testbench

- Upstream feeder for the serial number printer.
- Receives 8N1 UART bytes on the board RX pin and parses ASCII decimal digits terminated by CR or LF into an unsigned 32-bit value.
- Presents the value as a held register with a one-cycle valid pulse; the top level latches it into the printer's number input instead of the free-running counter.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 133 +++++++++++++
 rtl/uart_number_rx.sv | 84 ++++++++
 tb/tb_uart_number_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive constants: ASCII codes, RX state encoding, default bit timing.
// Pure declarations; no latency or flow control of its own.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchroniser; valid/frame_err pulse one cycle after
// the stop-bit sample. No backpressure: each byte is presented for exactly one cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic             rx_m;
  logic             rx_s;
  logic             rx_prev;
  logic [1:0]       sync_fill;
  logic             armed;
  logic             fall;

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             valid_nxt;
  logic             ferr_nxt;
  logic             expiry;

  // Sync flops come out of reset high, so their first outputs are not real line samples;
  // sync_fill marks when rx_s reflects the pin, and armed needs a genuine high before any start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_prev   <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_s);
    end
  end

  assign fall   = armed & rx_prev & ~rx_s;
  assign expiry = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (!expiry) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (rx_s) begin
          state_nxt = RX_IDLE;
        end else begin
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = '0;
          state_nxt   = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!expiry) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          shreg_nxt = {rx_s, shreg[7:1]};
          cnt_nxt   = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = RX_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (!expiry) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          valid_nxt = rx_s;
          ferr_nxt  = ~rx_s;
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign data = shreg;

endmodule

// File: rtl/uart_number_rx.sv
// Parses CR/LF-terminated ASCII decimal lines from a UART into a held NUM_W-bit number;
// number_valid pulses 1 clk after the terminator byte. No backpressure: bytes are consumed as they arrive.
module uart_number_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic [NUM_W-1:0] number,
  output logic             number_valid,
  output logic             byte_valid,
  output logic             frame_err,
  output logic             overflow
);

  logic [7:0]       rx_data;
  logic [NUM_W-1:0] acc;
  logic             digit_seen;
  logic             line_bad;
  logic             acc_ovf;
  logic [NUM_W+3:0] acc_wide;
  logic [NUM_W+3:0] acc_x10;
  logic [NUM_W+3:0] acc_next;
  logic             step_ovf;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_rx),
    .data     (rx_data),
    .valid    (byte_valid),
    .frame_err(frame_err)
  );

  // acc*10 + digit never exceeds 16*2^NUM_W, so four guard bits catch every wrap.
  assign acc_wide = {4'b0000, acc};
  assign acc_x10  = (acc_wide << 3) + (acc_wide << 1);
  assign acc_next = acc_x10 + {{NUM_W{1'b0}}, rx_data[3:0]};
  assign step_ovf = |acc_next[NUM_W+3:NUM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      digit_seen   <= 1'b0;
      line_bad     <= 1'b0;
      acc_ovf      <= 1'b0;
      number       <= '0;
      number_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      if (frame_err) begin
        line_bad <= 1'b1;
      end else if (byte_valid) begin
        if (is_digit(rx_data)) begin
          acc        <= acc_next[NUM_W-1:0];
          digit_seen <= 1'b1;
          if (step_ovf) begin
            acc_ovf <= 1'b1;
          end
        end else if (is_term(rx_data)) begin
          // An empty or poisoned line still resets the parser for the next one.
          if (digit_seen && !line_bad) begin
            number       <= acc;
            number_valid <= 1'b1;
            overflow     <= acc_ovf;
          end
          acc        <= '0;
          digit_seen <= 1'b0;
          line_bad   <= 1'b0;
          acc_ovf    <= 1'b0;
        end else begin
          line_bad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_number_rx.sv
// Directed bench for uart_number_rx at 8 clocks per bit: drives UART frames and checks
// committed numbers, overflow, pulse counts, framing errors, glitch rejection and reset.
module tb_uart_number_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [31:0] number;
  logic        number_valid;
  logic        byte_valid;
  logic        frame_err;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int nv_cnt = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int lat_bad = 0;
  logic bv_q = 1'b0;

  int nv0, bv0, fe0;

  uart_number_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_W       (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .number      (number),
    .number_valid(number_valid),
    .byte_valid  (byte_valid),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Pulse monitor; number_valid must always follow a byte_valid by exactly one cycle.
  always @(negedge clk) begin
    if (number_valid) begin
      nv_cnt++;
      if (!bv_q) lat_bad++;
    end
    if (byte_valid) bv_cnt++;
    if (frame_err) fe_cnt++;
    bv_q = byte_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(CPB);
    end
    uart_rx = stop_bit;
    wait_cyc(CPB);
    uart_rx = 1'b1;
    wait_cyc(CPB);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
    wait_cyc(2 * CPB);
  endtask

  task automatic snap();
    nv0 = nv_cnt;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    wait_cyc(3);
    check("rst_number", number, 0);
    check("rst_nv", number_valid, 0);
    check("rst_bv", byte_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    wait_cyc(4 * CPB);

    snap();
    send_str("1234\n");
    check("l1234_nv", nv_cnt - nv0, 1);
    check("l1234_num", number, 1234);
    check("l1234_ovf", overflow, 0);
    check("l1234_bv", bv_cnt - bv0, 5);
    check("l1234_fe", fe_cnt - fe0, 0);

    snap();
    send_str("4294967295\r\n");
    check("max_nv", nv_cnt - nv0, 1);
    check("max_num", number, 32'hFFFF_FFFF);
    check("max_ovf", overflow, 0);

    snap();
    send_str("4294967296\n");
    check("wrap_nv", nv_cnt - nv0, 1);
    check("wrap_num", number, 0);
    check("wrap_ovf", overflow, 1);

    snap();
    send_str("7\n");
    check("seven_num", number, 7);
    check("seven_ovf", overflow, 0);

    snap();
    send_str("12a4\n");
    send_str("\n");
    check("bad_nv", nv_cnt - nv0, 0);
    check("bad_num", number, 7);
    send_str("55\n");
    check("l55_nv", nv_cnt - nv0, 1);
    check("l55_num", number, 55);

    snap();
    send_byte(8'h35, 1'b0);
    wait_cyc(CPB);
    check("ferr_fe", fe_cnt - fe0, 1);
    check("ferr_bv", bv_cnt - bv0, 0);
    send_str("9\n");
    check("ferr_line_nv", nv_cnt - nv0, 0);
    check("ferr_line_num", number, 55);
    send_str("9\n");
    check("nine_nv", nv_cnt - nv0, 1);
    check("nine_num", number, 9);

    snap();
    uart_rx = 1'b0;
    wait_cyc(2);
    uart_rx = 1'b1;
    wait_cyc(5 * CPB);
    check("glitch_bv", bv_cnt - bv0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    send_str("3\n");
    check("three_num", number, 3);
    check("three_nv", nv_cnt - nv0, 1);

    // Reset lands in data bit 3 of the second '8' and releases during data bit 6 (line low).
    send_byte(8'h38, 1'b1);
    fork
      send_byte(8'h38, 1'b1);
      begin
        wait_cyc(36);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst_number", number, 0);
        check("midrst_nv", number_valid, 0);
        check("midrst_bv", byte_valid, 0);
        check("midrst_fe", frame_err, 0);
        check("midrst_ovf", overflow, 0);
        wait_cyc(21);
        rst_n = 1'b1;
      end
    join
    wait_cyc(4 * CPB);
    snap();
    send_str("6\n");
    check("post_rst_nv", nv_cnt - nv0, 1);
    check("post_rst_num", number, 6);
    check("post_rst_bv", bv_cnt - bv0, 2);
    check("post_rst_fe", fe_cnt - fe0, 0);

    check("nv_latency", lat_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
